// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing master: divides Clk by two into the pixel clock and
// produces raster counters plus registered sync, blank and frame/line markers.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       vga_clk,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned CW      = 10;
  localparam int unsigned FCW     = 8;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic           vclk_q, vclk_d;
  logic [CW-1:0]  x_q, x_d, y_q, y_d;
  logic [CW-1:0]  x_nxt, y_nxt;
  logic           blank_q, blank_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           ls_q, ls_d;
  logic           fs_q, fs_d;
  logic [FCW-1:0] fc_q, fc_d;

  // Raster advance on vga_clk rising edges; markers derive from the new position
  always_comb begin
    vclk_d  = ~vclk_q;
    x_d     = x_q;
    y_d     = y_q;
    blank_d = blank_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    ls_d    = ls_q;
    fs_d    = fs_q;
    fc_d    = fc_q;

    x_nxt = (x_q == H_LAST) ? '0 : x_q + CW'(1);
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      y_nxt = (y_q == V_LAST) ? '0 : y_q + CW'(1);
    end

    if (!vclk_q) begin
      x_d     = x_nxt;
      y_d     = y_nxt;
      blank_d = (x_nxt < H_VIS) && (y_nxt < V_VIS);
      hs_d    = !((x_nxt >= HS_BEGIN) && (x_nxt < HS_END));
      vs_d    = !((y_nxt >= VS_BEGIN) && (y_nxt < VS_END));
      ls_d    = (x_nxt == '0);
      fs_d    = (x_nxt == '0) && (y_nxt == '0);
      if ((x_nxt == '0) && (y_nxt == '0)) begin
        fc_d = fc_q + FCW'(1);
      end
    end
  end

  // Reset parks the raster on the last pixel so the first advance lands on (0,0)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vclk_q  <= 1'b0;
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      vclk_q  <= vclk_d;
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  assign vga_clk     = vclk_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign sync        = 1'b0;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance and a shrunken instance,
// both compared every Clk cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       vclk;
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  localparam int SHV = 6, SHF = 1, SHW = 2, SHB = 1;
  localparam int SVV = 3, SVF = 1, SVW = 1, SVB = 1;

  int checks = 0;
  int failures = 0;

  logic rst_d = 1'b1, rst_s = 1'b1;
  logic vclk_d, blank_d, hs_d, vs_d, sync_d, ls_d, fs_d;
  logic vclk_s, blank_s, hs_s, vs_s, sync_s, ls_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic [7:0] fc_d, fc_s;

  vga_timing_gen dut_dflt (
    .Clk(Clk), .Reset(rst_d), .vga_clk(vclk_d), .DrawX(x_d), .DrawY(y_d),
    .blank(blank_d), .hs(hs_d), .vs(vs_d), .sync(sync_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHW), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVW), .V_BACK(SVB)
  ) dut_small (
    .Clk(Clk), .Reset(rst_s), .vga_clk(vclk_s), .DrawX(x_s), .DrawY(y_s),
    .blank(blank_s), .hs(hs_s), .vs(vs_s), .sync(sync_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  // Clk edges since reset was last seen; 0 means reset values are expected
  int c_d = 0, c_s = 0;
  always @(posedge Clk) begin
    c_d <= rst_d ? 0 : c_d + 1;
    c_s <= rst_s ? 0 : c_s + 1;
  end

  // Raster position is a linear pixel index: one pixel per two Clk edges
  function automatic exp_t model(input int c, input int hv, input int hf, input int hw,
                                 input int hb, input int vv, input int vf, input int vw,
                                 input int vb);
    exp_t e;
    int ht, vt, k, idx, x, y;
    ht = hv + hf + hw + hb;
    vt = vv + vf + vw + vb;
    if (c == 0) begin
      e = '{vclk: 1'b0, x: 10'(ht - 1), y: 10'(vt - 1), blank: 1'b0, hs: 1'b1,
            vs: 1'b1, ls: 1'b0, fs: 1'b0, fc: 8'd0};
    end else begin
      k   = (c + 1) / 2;
      idx = (k - 1) % (ht * vt);
      x   = idx % ht;
      y   = idx / ht;
      e.vclk  = (c % 2) == 1;
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.blank = (x < hv) && (y < vv);
      e.hs    = !((x >= hv + hf) && (x < hv + hf + hw));
      e.vs    = !((y >= vv + vf) && (y < vv + vf + vw));
      e.ls    = (x == 0);
      e.fs    = (x == 0) && (y == 0);
      e.fc    = 8'(((k - 1) / (ht * vt) + 1) % 256);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string n, input exp_t e, input logic vc, input logic [9:0] x,
                         input logic [9:0] y, input logic b, input logic h, input logic v,
                         input logic s, input logic ls, input logic fs, input logic [7:0] fc);
    chk({n, ".vga_clk"}, 32'(vc), 32'(e.vclk));
    chk({n, ".DrawX"}, 32'(x), 32'(e.x));
    chk({n, ".DrawY"}, 32'(y), 32'(e.y));
    chk({n, ".blank"}, 32'(b), 32'(e.blank));
    chk({n, ".hs"}, 32'(h), 32'(e.hs));
    chk({n, ".vs"}, 32'(v), 32'(e.vs));
    chk({n, ".sync"}, 32'(s), 32'd0);
    chk({n, ".line_start"}, 32'(ls), 32'(e.ls));
    chk({n, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({n, ".frame_count"}, 32'(fc), 32'(e.fc));
  endtask

  bit count_hs = 1'b0;
  int hs_low = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      chk_all("dflt", model(c_d, 640, 16, 96, 48, 480, 10, 2, 33),
              vclk_d, x_d, y_d, blank_d, hs_d, vs_d, sync_d, ls_d, fs_d, fc_d);
      chk_all("small", model(c_s, SHV, SHF, SHW, SHB, SVV, SVF, SVW, SVB),
              vclk_s, x_s, y_s, blank_s, hs_s, vs_s, sync_s, ls_s, fs_s, fc_s);
      if (count_hs && c_d >= 1 && c_d <= 1600 && hs_d == 1'b0) hs_low++;
    end
  endtask

  initial begin
    int guard;
    int hold;
    int run;

    // Reset held for 3 cycles, then release both instances together
    step(3);
    rst_d = 1'b0;
    rst_s = 1'b0;
    count_hs = 1'b1;

    // First lines of the full-size raster: pacing, hsync window, line wrap
    step(3300);
    count_hs = 1'b0;
    chk("dflt.hs_low_clk_line0", 32'(hs_low), 32'd192);

    // Mid-frame reset of the full-size instance at DrawX=300 on line 3
    guard = 0;
    while (c_d != 5401 && guard < 10000) begin
      step(1);
      guard++;
    end
    chk("dflt.reach_x300", 32'(c_d), 32'd5401);
    rst_d = 1'b1;
    step(1);
    rst_d = 1'b0;
    step(4);

    // 257 small frames cover frame_count wrap 255 -> 0 and every vs window
    step(257 * 120 + 50);

    // Random reset pulses and run lengths on both instances
    repeat (20) begin
      hold = int'($urandom_range(1, 4));
      run  = int'($urandom_range(1, 300));
      if ($urandom_range(0, 1) == 1) rst_d = 1'b1;
      else rst_s = 1'b1;
      step(hold);
      rst_d = 1'b0;
      rst_s = 1'b0;
      step(run);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
